// File: rtl/axi_read_arbiter.sv
// Two-master AXI read arbiter: round-robin AR grant with a single transaction in
// flight; R beats are steered back to the granted master until the RLAST handshake.
module axi_read_arbiter #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   // master 0 AR channel
   input  logic [ID_W-1:0]   ARID_M0,
   input  logic [ADDR_W-1:0] ARADDR_M0,
   input  logic [LEN_W-1:0]  ARLEN_M0,
   input  logic [2:0]        ARSIZE_M0,
   input  logic [1:0]        ARBURST_M0,
   input  logic              ARVALID_M0,
   output logic              ARREADY_M0,
   // master 0 R channel
   output logic [ID_W-1:0]   RID_M0,
   output logic [DATA_W-1:0] RDATA_M0,
   output logic [1:0]        RRESP_M0,
   output logic              RLAST_M0,
   output logic              RVALID_M0,
   input  logic              RREADY_M0,
   // master 1 AR channel
   input  logic [ID_W-1:0]   ARID_M1,
   input  logic [ADDR_W-1:0] ARADDR_M1,
   input  logic [LEN_W-1:0]  ARLEN_M1,
   input  logic [2:0]        ARSIZE_M1,
   input  logic [1:0]        ARBURST_M1,
   input  logic              ARVALID_M1,
   output logic              ARREADY_M1,
   // master 1 R channel
   output logic [ID_W-1:0]   RID_M1,
   output logic [DATA_W-1:0] RDATA_M1,
   output logic [1:0]        RRESP_M1,
   output logic              RLAST_M1,
   output logic              RVALID_M1,
   input  logic              RREADY_M1,
   // slave AR channel
   output logic [ID_W+3:0]   ARID_S,
   output logic [ADDR_W-1:0] ARADDR_S,
   output logic [LEN_W-1:0]  ARLEN_S,
   output logic [2:0]        ARSIZE_S,
   output logic [1:0]        ARBURST_S,
   output logic              ARVALID_S,
   input  logic              ARREADY_S,
   // slave R channel
   input  logic [ID_W+3:0]   RID_S,
   input  logic [DATA_W-1:0] RDATA_S,
   input  logic [1:0]        RRESP_S,
   input  logic              RLAST_S,
   input  logic              RVALID_S,
   output logic              RREADY_S
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   gnt_q, gnt_d;     // 0 = M0 granted, 1 = M1 granted
   logic   last_q, last_d;   // master granted most recently
   logic   pick;
   logic   rready_g;
   logic   ar_fire;
   logic   r_last_fire;

   // Routing follows the registered grant, so the slave's tag bits are not needed.
   logic   unused_rid_tag;
   assign unused_rid_tag = ^RID_S[ID_W+3:ID_W];

   // Round-robin choice: a lone requester wins, a tie goes to the master not served last.
   always_comb begin
      if (ARVALID_M0 && ARVALID_M1) pick = ~last_q;
      else                          pick = ARVALID_M1;
   end

   assign rready_g    = gnt_q ? RREADY_M1 : RREADY_M0;
   assign ar_fire     = (state_q == ADDR) && ARREADY_S;
   assign r_last_fire = (state_q == DATA) && RVALID_S && rready_g && RLAST_S;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (ARVALID_M0 || ARVALID_M1) begin
               gnt_d   = pick;
               last_d  = pick;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (ar_fire) state_d = DATA;
         end
         DATA: begin
            if (r_last_fire) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ARID_S     = '0;
      ARADDR_S   = '0;
      ARLEN_S    = '0;
      ARSIZE_S   = '0;
      ARBURST_S  = '0;
      ARVALID_S  = 1'b0;
      ARREADY_M0 = 1'b0;
      ARREADY_M1 = 1'b0;
      RID_M0     = '0;
      RDATA_M0   = '0;
      RRESP_M0   = '0;
      RLAST_M0   = 1'b0;
      RVALID_M0  = 1'b0;
      RID_M1     = '0;
      RDATA_M1   = '0;
      RRESP_M1   = '0;
      RLAST_M1   = 1'b0;
      RVALID_M1  = 1'b0;
      RREADY_S   = 1'b0;
      case (state_q)
         ADDR: begin
            ARVALID_S = 1'b1;
            if (gnt_q) begin
               ARID_S     = {4'b0010, ARID_M1};
               ARADDR_S   = ARADDR_M1;
               ARLEN_S    = ARLEN_M1;
               ARSIZE_S   = ARSIZE_M1;
               ARBURST_S  = ARBURST_M1;
               ARREADY_M1 = ARREADY_S;
            end else begin
               ARID_S     = {4'b0001, ARID_M0};
               ARADDR_S   = ARADDR_M0;
               ARLEN_S    = ARLEN_M0;
               ARSIZE_S   = ARSIZE_M0;
               ARBURST_S  = ARBURST_M0;
               ARREADY_M0 = ARREADY_S;
            end
         end
         DATA: begin
            RREADY_S = rready_g;
            if (gnt_q) begin
               RID_M1    = RID_S[ID_W-1:0];
               RDATA_M1  = RDATA_S;
               RRESP_M1  = RRESP_S;
               RLAST_M1  = RLAST_S;
               RVALID_M1 = RVALID_S;
            end else begin
               RID_M0    = RID_S[ID_W-1:0];
               RDATA_M0  = RDATA_S;
               RRESP_M0  = RRESP_S;
               RLAST_M0  = RLAST_S;
               RVALID_M0 = RVALID_S;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: directed master requests, a reactive slave
// model, and a monitor that pops expected AR/R traffic on every handshake.
module tb_axi_read_arbiter;

   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [ID_W-1:0]   ARID_M0, ARID_M1, RID_M0, RID_M1;
   logic [ADDR_W-1:0] ARADDR_M0, ARADDR_M1, ARADDR_S;
   logic [LEN_W-1:0]  ARLEN_M0, ARLEN_M1, ARLEN_S;
   logic [2:0]        ARSIZE_M0, ARSIZE_M1, ARSIZE_S;
   logic [1:0]        ARBURST_M0, ARBURST_M1, ARBURST_S;
   logic              ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
   logic [DATA_W-1:0] RDATA_M0, RDATA_M1, RDATA_S;
   logic [1:0]        RRESP_M0, RRESP_M1, RRESP_S;
   logic              RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
   logic [ID_W+3:0]   ARID_S, RID_S;
   logic              ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S;

   axi_read_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst),
      .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
      .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
      .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
      .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
      .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
      .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
      .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
      .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
      .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
      .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
      .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
      .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
   );

   typedef struct {
      logic [ID_W+3:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
   } ar_t;

   typedef struct {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
      logic [1:0]        resp;
      logic              last;
   } r_t;

   ar_t exp_ar[$];
   r_t  exp_r0[$];
   r_t  exp_r1[$];
   ar_t mon_ar;
   r_t  mon_r;

   int checks   = 0;
   int failures = 0;
   int nr0 = 0, nr1 = 0, done0 = 0, done1 = 0;
   int ar_stall = 0;

   logic              cap_arvalid_s, cap_arready_m0, cap_arready_m1, cap_rready_s;
   logic              cap_rvalid_m0, cap_rvalid_m1;
   logic [ID_W+3:0]   cap_arid_s;
   logic [ADDR_W-1:0] cap_araddr_s;
   logic [DATA_W-1:0] cap_rdata_m0, cap_rdata_m1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
      end
   endtask

   // Slave read data is a fixed function of the beat address.
   function automatic logic [DATA_W-1:0] rdata_of(input logic [ADDR_W-1:0] a, input int b);
      logic [ADDR_W-1:0] off;
      off = ADDR_W'(b * 4);
      return (a + off) ^ 32'hDEADAEEF;
   endfunction

   task automatic issue(input int m, input logic [ID_W-1:0] id,
                        input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
      ar_t ea;
      r_t  er;
      ea.id   = {(m == 0) ? 4'b0001 : 4'b0010, id};
      ea.addr = addr;
      ea.len  = len;
      exp_ar.push_back(ea);
      for (int b = 0; b <= int'(len); b++) begin
         er.id   = id;
         er.data = rdata_of(addr, b);
         er.resp = 2'(b);
         er.last = (b == int'(len));
         if (m == 0) exp_r0.push_back(er);
         else        exp_r1.push_back(er);
      end
      if (m == 0) begin
         ARID_M0 = id; ARADDR_M0 = addr; ARLEN_M0 = len;
         ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'b01; ARVALID_M0 = 1'b1;
      end else begin
         ARID_M1 = id; ARADDR_M1 = addr; ARLEN_M1 = len;
         ARSIZE_M1 = 3'd2; ARBURST_M1 = 2'b01; ARVALID_M1 = 1'b1;
      end
   endtask

   // One cycle: sample away from the edge, then step to just after the next rising edge.
   task automatic tick();
      logic h0, h1;
      @(negedge clk);
      h0 = ARVALID_M0 && ARREADY_M0;
      h1 = ARVALID_M1 && ARREADY_M1;
      if (RVALID_M0 && RREADY_M0) begin nr0++; if (RLAST_M0) done0++; end
      if (RVALID_M1 && RREADY_M1) begin nr1++; if (RLAST_M1) done1++; end
      cap_arvalid_s  = ARVALID_S;
      cap_arready_m0 = ARREADY_M0;
      cap_arready_m1 = ARREADY_M1;
      cap_rready_s   = RREADY_S;
      cap_rvalid_m0  = RVALID_M0;
      cap_rvalid_m1  = RVALID_M1;
      cap_arid_s     = ARID_S;
      cap_araddr_s   = ARADDR_S;
      cap_rdata_m0   = RDATA_M0;
      cap_rdata_m1   = RDATA_M1;
      @(posedge clk);
      #1;
      if (h0) ARVALID_M0 = 1'b0;
      if (h1) ARVALID_M1 = 1'b0;
   endtask

   function automatic int cnt_of(input int sel);
      case (sel)
         0:       return done0;
         1:       return done1;
         2:       return nr1;
         default: return nr0;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int target, input string nm);
      int n = 0;
      while (cnt_of(sel) < target && n < 60) begin
         tick();
         n++;
      end
      chk(nm, cnt_of(sel), target);
   endtask

   // Slave model: ARREADY after ar_stall cycles of ARVALID_S, then ARLEN+1 beats.
   int                rs_state, rs_cnt, rs_beat;
   logic [LEN_W-1:0]  rs_len;
   logic [ADDR_W-1:0] rs_addr;
   logic [ID_W+3:0]   rs_id;
   logic              s_arhs, s_rhs, s_arv;

   task automatic present_beat();
      RVALID_S = 1'b1;
      RID_S    = rs_id;
      RDATA_S  = rdata_of(rs_addr, rs_beat);
      RRESP_S  = 2'(rs_beat);
      RLAST_S  = (rs_beat == int'(rs_len));
   endtask

   initial begin
      ARREADY_S = 1'b0; RVALID_S = 1'b0; RDATA_S = '0; RID_S = '0; RRESP_S = '0; RLAST_S = 1'b0;
      rs_state = 0; rs_cnt = 0; rs_beat = 0; rs_len = '0; rs_addr = '0; rs_id = '0;
      forever begin
         @(negedge clk);
         s_arhs = ARVALID_S && ARREADY_S;
         s_rhs  = RVALID_S && RREADY_S;
         s_arv  = ARVALID_S;
         if (s_arhs) begin rs_addr = ARADDR_S; rs_id = ARID_S; rs_len = ARLEN_S; end
         @(posedge clk);
         #1;
         if (rst) begin
            rs_state = 0; rs_cnt = 0; ARREADY_S = 1'b0;
            RVALID_S = 1'b0; RLAST_S = 1'b0; RDATA_S = '0; RID_S = '0; RRESP_S = '0;
         end else if (rs_state == 0) begin
            if (s_arhs) begin
               rs_state = 1; rs_beat = 0; rs_cnt = 0; ARREADY_S = 1'b0;
               present_beat();
            end else if (ar_stall == 0) begin
               ARREADY_S = 1'b1;
            end else begin
               if (s_arv) rs_cnt++;
               ARREADY_S = (rs_cnt >= ar_stall);
            end
         end else if (s_rhs) begin
            if (RLAST_S) begin
               rs_state = 0; RVALID_S = 1'b0; RLAST_S = 1'b0; RDATA_S = '0;
               ARREADY_S = (ar_stall == 0);
            end else begin
               rs_beat++;
               present_beat();
            end
         end
      end
   end

   // Monitor: every handshake pops and checks the next expected item.
   initial begin
      forever begin
         @(negedge clk);
         if (ARVALID_S && ARREADY_S) begin
            if (exp_ar.size() == 0) begin
               checks++; failures++;
               $display("FAIL ar_unexpected actual=0x%0h required=none", ARID_S);
            end else begin
               mon_ar = exp_ar.pop_front();
               chk("ar_id", ARID_S, mon_ar.id);
               chk("ar_addr", ARADDR_S, mon_ar.addr);
               chk("ar_len", ARLEN_S, mon_ar.len);
               chk("ar_size", ARSIZE_S, 3'd2);
            end
         end
         if (RVALID_M0 || RVALID_M1) chk("rvalid_exclusive", RVALID_M0 & RVALID_M1, 1'b0);
         if (RVALID_M0 && RREADY_M0) begin
            if (exp_r0.size() == 0) begin
               checks++; failures++;
               $display("FAIL r0_unexpected actual=0x%0h required=none", RDATA_M0);
            end else begin
               mon_r = exp_r0.pop_front();
               chk("r0_id", RID_M0, mon_r.id);
               chk("r0_data", RDATA_M0, mon_r.data);
               chk("r0_resp", RRESP_M0, mon_r.resp);
               chk("r0_last", RLAST_M0, mon_r.last);
            end
         end
         if (RVALID_M1 && RREADY_M1) begin
            if (exp_r1.size() == 0) begin
               checks++; failures++;
               $display("FAIL r1_unexpected actual=0x%0h required=none", RDATA_M1);
            end else begin
               mon_r = exp_r1.pop_front();
               chk("r1_id", RID_M1, mon_r.id);
               chk("r1_data", RDATA_M1, mon_r.data);
               chk("r1_resp", RRESP_M1, mon_r.resp);
               chk("r1_last", RLAST_M1, mon_r.last);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      rst = 1'b1;
      ARID_M0 = '0; ARADDR_M0 = '0; ARLEN_M0 = '0; ARSIZE_M0 = '0; ARBURST_M0 = '0; ARVALID_M0 = 1'b0;
      ARID_M1 = '0; ARADDR_M1 = '0; ARLEN_M1 = '0; ARSIZE_M1 = '0; ARBURST_M1 = '0; ARVALID_M1 = 1'b0;
      RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;

      // reset state
      tick();
      tick();
      chk("rst_arvalid_s", cap_arvalid_s, 1'b0);
      chk("rst_arready_m0", cap_arready_m0, 1'b0);
      chk("rst_arready_m1", cap_arready_m1, 1'b0);
      chk("rst_rvalid_m0", cap_rvalid_m0, 1'b0);
      chk("rst_rvalid_m1", cap_rvalid_m1, 1'b0);
      chk("rst_rready_s", cap_rready_s, 1'b0);
      chk("rst_arid_s", cap_arid_s, 8'h00);
      chk("rst_rdata_m0", cap_rdata_m0, 32'h0);
      rst = 1'b0;
      tick();

      // single M0 read
      issue(0, 4'd3, 32'h0000_1000, 4'd0);
      tick();
      chk("t1_c0_arvalid_s", cap_arvalid_s, 1'b0);
      tick();
      chk("t1_c1_arvalid_s", cap_arvalid_s, 1'b1);
      chk("t1_c1_arid_s", cap_arid_s, 8'h13);
      tick();
      chk("t1_rvalid_m0", cap_rvalid_m0, 1'b1);
      chk("t1_rdata_m0", cap_rdata_m0, 32'hDEADBEEF);
      chk("t1_rvalid_m1_low", cap_rvalid_m1, 1'b0);
      wait_for(0, 1, "t1_done");

      // ties after reset: M0, then M1 right after M0's RLAST, then M0 again
      rst = 1'b1;
      tick();
      rst = 1'b0;
      issue(0, 4'd1, 32'h0000_2000, 4'd0);
      issue(1, 4'd2, 32'h0000_3000, 4'd0);
      wait_for(0, done0 + 1, "t2_m0_first");
      tick();
      chk("t2_idle_gap", cap_arvalid_s, 1'b0);
      tick();
      chk("t2_m1_arvalid", cap_arvalid_s, 1'b1);
      chk("t2_m1_arid", cap_arid_s, 8'h22);
      wait_for(1, done1 + 1, "t2_m1_done");
      issue(0, 4'd4, 32'h0000_4000, 4'd0);
      issue(1, 4'd5, 32'h0000_5000, 4'd0);
      tick();
      tick();
      chk("t2_third_tie_arid", cap_arid_s, 8'h14);
      wait_for(0, done0 + 1, "t2_tie3_m0_done");
      wait_for(1, done1 + 1, "t2_tie3_m1_done");

      // slave holds ARREADY low for five cycles
      ar_stall = 5;
      tick();
      issue(0, 4'd6, 32'h0000_6000, 4'd0);
      tick();
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("t3_stall_arvalid", cap_arvalid_s, 1'b1);
         chk("t3_stall_araddr", cap_araddr_s, 32'h0000_6000);
         chk("t3_stall_arid", cap_arid_s, 8'h16);
         chk("t3_stall_arready_m0", cap_arready_m0, 1'b0);
      end
      tick();
      chk("t3_hs_arready_m0", cap_arready_m0, 1'b1);
      wait_for(0, done0 + 1, "t3_done");
      ar_stall = 0;

      // M1 four-beat burst, master back-pressure on beat 2, M0 request held off
      base = nr1;
      issue(1, 4'd7, 32'h0000_7000, 4'd3);
      wait_for(2, base + 1, "t4_beat1");
      RREADY_M1 = 1'b0;
      issue(0, 4'd8, 32'h0000_8000, 4'd1);
      tick();
      chk("t4_stall_rready_s", cap_rready_s, 1'b0);
      chk("t4_stall_rvalid_m1", cap_rvalid_m1, 1'b1);
      chk("t4_stall_arready_m0", cap_arready_m0, 1'b0);
      RREADY_M1 = 1'b1;
      wait_for(2, base + 3, "t4_beat3");
      tick();
      chk("t4_beat4_still_data", cap_rvalid_m1, 1'b1);
      chk("t4_beat4_no_ar", cap_arvalid_s, 1'b0);
      wait_for(1, done1 + 0, "t4_m1_done");
      wait_for(0, done0 + 1, "t4_m0_done");

      // asynchronous reset in the middle of beat 2, pending M1 request afterwards
      base = nr1;
      issue(1, 4'd9, 32'h0000_9000, 4'd3);
      wait_for(2, base + 1, "t5_beat1");
      #2;
      rst = 1'b1;
      #1;
      chk("t5_async_rvalid_m1", RVALID_M1, 1'b0);
      chk("t5_async_rdata_m1", RDATA_M1, 32'h0);
      chk("t5_async_rid_m1", RID_M1, 4'h0);
      chk("t5_async_rready_s", RREADY_S, 1'b0);
      chk("t5_async_arvalid_s", ARVALID_S, 1'b0);
      exp_r1.delete();
      issue(1, 4'hA, 32'h0000_A000, 4'd0);
      tick();
      chk("t5_rst_arready_m1", cap_arready_m1, 1'b0);
      rst = 1'b0;
      tick();
      chk("t5_release_idle", cap_arvalid_s, 1'b0);
      tick();
      chk("t5_regrant_arvalid", cap_arvalid_s, 1'b1);
      chk("t5_regrant_arid", cap_arid_s, 8'h2A);
      wait_for(1, done1 + 1, "t5_done");

      tick();
      chk("end_ar_queue_empty", exp_ar.size(), 0);
      chk("end_r0_queue_empty", exp_r0.size(), 0);
      chk("end_r1_queue_empty", exp_r1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 SHALL have parameter ID_W, default 4, master-side AXI ID width.
REQ-002 SHALL have parameter ADDR_W, default 32, address width; DATA_W, default 32, data width; LEN_W, default 4, burst-length width.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports ARID_M0/ARID_M1  in  ID_W  master read IDs.
REQ-006 SHALL have ports ARADDR_Mx in ADDR_W, ARLEN_Mx in LEN_W, ARSIZE_Mx in 3, ARBURST_Mx in 2  (x=0,1)  master AR payloads.
REQ-007 SHALL have ports ARVALID_Mx  in  1  and  ARREADY_Mx  out  1  master AR handshakes.
REQ-008 SHALL have ports RID_Mx out ID_W, RDATA_Mx out DATA_W, RRESP_Mx out 2, RLAST_Mx out 1, RVALID_Mx out 1  master R channels.
REQ-009 SHALL have ports RREADY_Mx  in  1  master R acceptance.
REQ-010 SHALL have ports ARID_S out ID_W+4, ARADDR_S out ADDR_W, ARLEN_S out LEN_W, ARSIZE_S out 3, ARBURST_S out 2, ARVALID_S out 1, ARREADY_S in 1  slave AR channel.
REQ-011 SHALL have ports RID_S in ID_W+4, RDATA_S in DATA_W, RRESP_S in 2, RLAST_S in 1, RVALID_S in 1, RREADY_S out 1  slave R channel.

Function
REQ-012 SHALL implement FSM states IDLE, ADDR, DATA; one transaction outstanding at a time.
REQ-013 SHALL, in IDLE, when any ARVALID_Mx is high, register grant and move to ADDR next cycle; ARVALID_S stays low in IDLE.
REQ-014 SHALL, with exactly one requester, grant that requester; with both, grant the master not granted last (round-robin); after reset, M0 wins the first tie.
REQ-015 SHALL update the last-granted register only on the IDLE->ADDR transition.
REQ-016 SHALL, in ADDR, drive slave AR payload combinationally from the granted master, ARVALID_S=1, ARID_S={4'b0001 (M0) or 4'b0010 (M1), ARID_Mg}.
REQ-017 SHALL drive ARREADY_Mg=ARREADY_S in ADDR only; ARREADY of the other master and all ARREADY outside ADDR are 0.
REQ-018 SHALL move ADDR->DATA on ARVALID_S & ARREADY_S; otherwise hold ADDR indefinitely.
REQ-019 SHALL, in DATA, route RVALID_S, RDATA_S, RRESP_S, RLAST_S to granted master, RID_Mg=RID_S[ID_W-1:0], RREADY_S=RREADY_Mg.
REQ-020 SHALL hold the non-granted master's RVALID at 0 and its R payload at 0; RREADY_S=0 outside DATA.
REQ-021 SHALL move DATA->IDLE on RVALID_S & RREADY_S & RLAST_S; non-last beats keep DATA.
REQ-022 SHALL route R beats by the registered grant regardless of RID_S tag bits.
REQ-023 SHALL have minimum transaction latency: request seen cycle 0, ARVALID_S cycle 1, earliest new grant the cycle after the RLAST handshake.
REQ-024 SHALL ignore ARVALID changes of the non-granted master during ADDR/DATA; its request is served next IDLE.
REQ-025 SHALL support ARLEN up to 2^LEN_W-1 (burst count not tracked; RLAST terminates).

Reset
REQ-026 SHALL, on rst high at any time including mid-burst, force state IDLE, last-granted=M1 (so M0 wins next tie), all valid/ready outputs 0, all payload outputs 0.
REQ-027 SHALL resume arbitration on the first rising clk edge after rst deasserts.

Verification
REQ-028 Single M0 read: ARVALID_M0=1, ARADDR_M0=0x0000_1000, ARID_M0=3, ARLEN=0 -> ARVALID_S cycle 1, ARID_S=0x13, RDATA_S=0xDEADBEEF with RLAST delivered on RDATA_M0; RVALID_M1 stays 0.
REQ-029 Simultaneous requests after reset -> M0 granted first, M1 granted in the IDLE after M0's RLAST handshake; third tie goes to M0.
REQ-030 ARREADY_S held low 5 cycles -> ARVALID_S and payload stable for 5 cycles, ARREADY_M0 pulses only on handshake cycle.
REQ-031 M1 burst ARLEN=3 with RREADY_M1 deasserted on beat 2 -> RREADY_S=0 that cycle, four beats delivered in order, return to IDLE only after beat 4 (RLAST).
REQ-032 rst asserted during DATA beat 2 -> all outputs 0 immediately (asynchronous); after release, pending M1 request granted cleanly with ARID_S=0x2_.
